// File: rtl/load_align_if.sv
// Handshake and memory bus bundle for load_align_unit.
// The master side issues load requests, returns memory data and accepts the writeback result.
interface load_align_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = 2,
    parameter int unsigned TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [OFF_W-1:0]  alu;
    logic [1:0]        size;
    logic              sign;
    logic [TAG_W-1:0]  tag;
    logic              mem_rd_en;
    logic              mem_sel;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic [DATA_W-1:0] nd;
    logic [TAG_W-1:0]  nd_tag;
    logic              nd_valid;
    logic              nd_ready;

    modport master (
        output req_valid, alu, size, sign, tag, mem_data, mem_valid, nd_ready,
        input  req_ready, mem_rd_en, mem_sel, nd, nd_tag, nd_valid
    );

    modport slave (
        input  req_valid, alu, size, sign, tag, mem_data, mem_valid, nd_ready,
        output req_ready, mem_rd_en, mem_sel, nd, nd_tag, nd_valid
    );
endinterface

// File: rtl/load_align_unit.sv
// Load data path: issues one or two word reads, extracts and extends the addressed field.
// Optional MISALIGN_TRAP_EN: word-crossing loads trap (trap port) instead of issuing a second read.
module load_align_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = 2,
    parameter int unsigned TAG_W  = 5
) (
    input logic        clk,
    input logic        reset,
    load_align_if.slave bus
`ifdef MISALIGN_TRAP_EN
    ,
    output logic       trap
`endif
);
    localparam int unsigned N  = DATA_W / 8;
    localparam int unsigned SW = OFF_W + 2;

    typedef enum logic [1:0] {StIdle, StWait0, StWait1, StOut} state_e;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  alu_q, alu_d;
    logic [1:0]        szl_q, szl_d;
    logic              sign_q, sign_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              rd_en_q, rd_en_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] nd_q, nd_d;
    logic [TAG_W-1:0]  nd_tag_q, nd_tag_d;
`ifdef MISALIGN_TRAP_EN
    logic              trap_q, trap_d;
`endif

    logic [SW-1:0]     span;
    logic              split;
    logic [DATA_W-1:0] hi_w, lo_w, field, result;

    // szl_q holds log2 of the access size already clamped to a full word
    always_comb begin
        span  = SW'(alu_q) + (SW'(1) << szl_q);
        split = span > SW'(N);
    end

    // Field extraction: the high word only participates once the second read returns
    always_comb begin
        hi_w   = (state_q == StWait1) ? bus.mem_data : '0;
        lo_w   = (state_q == StWait1) ? lo_q : bus.mem_data;
        field  = DATA_W'({hi_w, lo_w} >> {alu_q, 3'b000});
        result = field;
        for (int k = 0; k <= int'(OFF_W); k++) begin
            if (int'(szl_q) == k) begin
                for (int b = 8 << k; b < int'(DATA_W); b++) begin
                    result[b] = sign_q ? 1'b0 : field[(8 << k) - 1];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        alu_d    = alu_q;
        szl_d    = szl_q;
        sign_d   = sign_q;
        tag_d    = tag_q;
        lo_d     = lo_q;
        rd_en_d  = 1'b0;
        sel_d    = 1'b0;
        nd_d     = nd_q;
        nd_tag_d = nd_tag_q;
`ifdef MISALIGN_TRAP_EN
        trap_d   = trap_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    alu_d   = bus.alu;
                    szl_d   = (32'(bus.size) > OFF_W) ? 2'(OFF_W) : bus.size;
                    sign_d  = bus.sign;
                    tag_d   = bus.tag;
                    rd_en_d = 1'b1;
                    state_d = StWait0;
                end
            end
            StWait0: begin
                if (bus.mem_valid) begin
                    lo_d = bus.mem_data;
                    if (split) begin
`ifdef MISALIGN_TRAP_EN
                        nd_d     = '0;
                        nd_tag_d = tag_q;
                        trap_d   = 1'b1;
                        state_d  = StOut;
`else
                        rd_en_d  = 1'b1;
                        sel_d    = 1'b1;
                        state_d  = StWait1;
`endif
                    end else begin
                        nd_d     = result;
                        nd_tag_d = tag_q;
`ifdef MISALIGN_TRAP_EN
                        trap_d   = 1'b0;
`endif
                        state_d  = StOut;
                    end
                end
            end
            StWait1: begin
                if (bus.mem_valid) begin
                    nd_d     = result;
                    nd_tag_d = tag_q;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (bus.nd_ready) begin
`ifdef MISALIGN_TRAP_EN
                    trap_d  = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            alu_q    <= '0;
            szl_q    <= '0;
            sign_q   <= 1'b0;
            tag_q    <= '0;
            lo_q     <= '0;
            rd_en_q  <= 1'b0;
            sel_q    <= 1'b0;
            nd_q     <= '0;
            nd_tag_q <= '0;
`ifdef MISALIGN_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            alu_q    <= alu_d;
            szl_q    <= szl_d;
            sign_q   <= sign_d;
            tag_q    <= tag_d;
            lo_q     <= lo_d;
            rd_en_q  <= rd_en_d;
            sel_q    <= sel_d;
            nd_q     <= nd_d;
            nd_tag_q <= nd_tag_d;
`ifdef MISALIGN_TRAP_EN
            trap_q   <= trap_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == StIdle) && !reset;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_sel   = sel_q;
    assign bus.nd        = nd_q;
    assign bus.nd_tag    = nd_tag_q;
    assign bus.nd_valid  = (state_q == StOut);
`ifdef MISALIGN_TRAP_EN
    assign trap          = trap_q;
`endif
endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed cases plus randomized loads vs a byte-level model.
module tb_load_align_unit;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic trap;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_nd;
    logic [4:0]  exp_tag;
    logic        exp_trap;
    bit          expect_out = 0;
    bit          lv = 0, pv = 0, pr = 0, prst = 1;

    always #5 clk = ~clk;

    load_align_if #(.DATA_W(32), .OFF_W(2), .TAG_W(5)) bus ();

`ifdef MISALIGN_TRAP_EN
    load_align_unit #(.DATA_W(32), .OFF_W(2), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .bus(bus), .trap(trap)
    );
`else
    load_align_unit #(.DATA_W(32), .OFF_W(2), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    assign trap = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bytes S = 2^min(size,2); crossing when offset + S exceeds the 4-byte word
    function automatic bit split_of(input logic [1:0] a, input logic [1:0] sz);
        int s;
        s = 1 << ((sz > 2) ? 2 : int'(sz));
        return (int'(a) + s) > 4;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] a, input logic [1:0] sz,
                                          input logic sg, input logic [31:0] lo,
                                          input logic [31:0] hi);
        int s;
        logic [63:0] w, f, m;
        s = 1 << ((sz > 2) ? 2 : int'(sz));
        w = split_of(a, sz) ? {hi, lo} : {32'h0, lo};
        m = (64'd1 << (8 * s)) - 64'd1;
        f = (w >> (8 * int'(a))) & m;
        if (!sg && f[8 * s - 1]) f = f | ~m;
        return f[31:0];
    endfunction

    // Compare process: every cycle a result is presented
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.nd_valid) begin
                if (!expect_out) begin
                    chk("stray_nd_valid", 32'(bus.nd_valid), 32'(expect_out));
                end else begin
                    chk("nd", bus.nd, exp_nd);
                    chk("nd_tag", 32'(bus.nd_tag), 32'(exp_tag));
                    chk("trap", 32'(trap), 32'(exp_trap));
                end
            end
            if (pv && !pr && !prst) chk("nd_valid_held", 32'(bus.nd_valid), 32'd1);
        end
        lv = bus.nd_valid;
    end

    always @(posedge clk) begin
        pv   = lv;
        pr   = bus.nd_ready;
        prst = reset;
    end

    task automatic abort_seq(input logic [31:0] stale);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_nd_valid", 32'(bus.nd_valid), 32'd0);
        chk("rst_nd", bus.nd, 32'd0);
        reset = 1'b0;
        expect_out = 0;
        bus.mem_valid = 1'b1;
        bus.mem_data  = stale;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("abort_nd", bus.nd, 32'd0);
        chk("abort_nd_tag", 32'(bus.nd_tag), 32'd0);
        chk("abort_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("abort_sel", 32'(bus.mem_sel), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nd_valid", 32'(bus.nd_valid), 32'd0);
        end
    endtask

    task automatic run_load(input logic [1:0] a, input logic [1:0] sz, input logic sg,
                            input logic [4:0] tg, input logic [31:0] lo, input logic [31:0] hi,
                            input logic [31:0] lit, input bit use_lit, input int lat,
                            input int stall, input bit junk, input bit abort);
        int n = 0, idx = 0, reads = 0, pend = 0, exp_reads;
        bit cur_sel = 0, seen = 0, sp;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.alu = a;
        bus.size = sz;
        bus.sign = sg;
        bus.tag = tg;
        @(posedge clk);
        sp        = split_of(a, sz);
        exp_reads = (sp && !TRAP) ? 2 : 1;
        exp_trap  = TRAP && sp;
        exp_nd    = use_lit ? lit : (exp_trap ? 32'h0 : model(a, sz, sg, lo, hi));
        exp_tag   = tg;
        expect_out = 1;
        #1;
        if (junk) begin
            bus.alu  = 2'($urandom);
            bus.size = 2'($urandom);
            bus.sign = 1'($urandom);
            bus.tag  = 5'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end
        while (!seen && idx < 60) begin
            @(negedge clk);
            idx++;
            bus.mem_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = cur_sel ? hi : lo;
                end
            end
            if (bus.mem_rd_en) begin
                reads++;
                chk("mem_sel", 32'(bus.mem_sel), 32'(reads == 2));
                cur_sel = bus.mem_sel;
                pend = lat;
                if (abort && reads == exp_reads) begin
                    abort_seq(lo);
                    return;
                end
            end
            if (bus.nd_valid) seen = 1;
        end
        chk("result_seen", 32'(seen), 32'd1);
        chk("read_count", 32'(reads), 32'(exp_reads));
        chk("latency", 32'(idx), 32'(exp_reads * (lat + 1) + 1));
        for (int i = 0; i < stall; i++) begin
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        chk("req_ready_out", 32'(bus.req_ready), 32'd0);
        bus.nd_ready  = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.nd_ready = 1'b0;
        expect_out = 0;
        chk("nd_valid_drop", 32'(bus.nd_valid), 32'd0);
        chk("req_ready_next", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.alu = '0;
        bus.size = '0;
        bus.sign = 1'b0;
        bus.tag = '0;
        bus.mem_data = '0;
        bus.mem_valid = 1'b0;
        bus.nd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_nd_valid", 32'(bus.nd_valid), 32'd0);
        chk("reset_nd", bus.nd, 32'd0);
        chk("reset_nd_tag", 32'(bus.nd_tag), 32'd0);
        chk("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("reset_sel", 32'(bus.mem_sel), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        chk("model_byte_neg", model(2'd1, 2'd0, 1'b0, 32'h0000FFFF, 32'h0), 32'hFFFFFFFF);
        chk("model_split_half", model(2'd3, 2'd1, 1'b1, 32'hAB000000, 32'h000000CD),
            32'h0000CDAB);

        run_load(2'd1, 2'd0, 1'b1, 5'd5, 32'h0000FFFF, 32'h0, 32'h000000FF, 1, 1, 0, 0, 0);
        run_load(2'd1, 2'd0, 1'b0, 5'd9, 32'h0000FFFF, 32'h0, 32'hFFFFFFFF, 1, 1, 0, 0, 0);
        run_load(2'd2, 2'd1, 1'b0, 5'd17, 32'h80010000, 32'h0, 32'hFFFF8001, 1, 1, 0, 0, 0);
        run_load(2'd3, 2'd1, 1'b1, 5'd3, 32'hAB000000, 32'h000000CD,
                 TRAP ? 32'h0 : 32'h0000CDAB, 1, 1, 0, 0, 0);
        run_load(2'd0, 2'd2, 1'b0, 5'd30, 32'h12345678, 32'h0, 32'h12345678, 1, 2, 3, 1, 0);
        run_load(2'd0, 2'd3, 1'b0, 5'd1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 1, 0, 0, 0);

        // Stray memory response while idle must not produce a result
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_idle_valid", 32'(bus.nd_valid), 32'd0);
            chk("stray_idle_rd_en", 32'(bus.mem_rd_en), 32'd0);
        end

        run_load(2'd3, 2'd1, 1'b0, 5'd22, 32'h11000000, 32'h00000022, 32'h0, 0, 1, 0, 0, 1);
        run_load(2'd2, 2'd0, 1'b0, 5'd7, 32'h00800000, 32'h0, 32'hFFFFFF80, 1, 1, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            run_load(2'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), $urandom,
                     $urandom, 32'h0, 0, int'($urandom_range(1, 3)),
                     int'($urandom_range(0, 2)), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential, parametrised load-data path between data memory and Register File writeback.
- Accepts a load request (byte offset, size, signedness, destination tag) and issues one or two memory reads.
- Extracts and aligns the addressed field and sign/zero-extends it to DATA_W.
- Delivers the result with a valid/ready handshake; supports loads that cross a word boundary.

Parameters:
DATA_W, 32, datapath width in bits; multiple of 8, power-of-two byte count N=DATA_W/8 >= 2
OFF_W, 2, byte-offset width; must equal log2(N)
TAG_W, 5, destination-register tag width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  1  load request valid
ReqReady  out  1  unit can accept a request
ALU  in  OFF_W  byte offset within the word (low address bits)
Size  in  2  log2 of byte count: 0 = byte, 1 = half, 2 = word, 3 = dword; values above log2(N) are treated as full word
Sign  in  1  1 = unsigned (zero-extend), 0 = signed (sign-extend)
Tag  in  TAG_W  destination register
MemRdEn  out  1  one-cycle read strobe
MemSel  out  1  0 = aligned word, 1 = next word
MemData  in  DATA_W  read data
MemValid  in  1  MemData valid (latency >= 1 after MemRdEn)
ND  out  DATA_W  extended load result
NDTag  out  TAG_W  tag of ND
NDValid  out  1  result valid
NDReady  in  1  writeback accepts result

Behaviour:
- Reset behaviour: Reset=1 at a rising edge forces IDLE and clears all registered state. ND=0, NDTag=0, NDValid=0, MemRdEn=0, MemSel=0. ReqReady=0 while Reset is high.
- FSM states: IDLE, WAIT0, WAIT1, OUT.
- Derived values: S = 1<<min(Size, log2 N); Split = (ALU + S > N).
- IDLE:
  - ReqReady=1.
  - On ReqValid, latch ALU/Size/Sign/Tag.
  - Next cycle: MemRdEn=1 and MemSel=0 for exactly one cycle; go to WAIT0.
- WAIT0:
  - On MemValid, capture Lo=MemData.
  - If Split: MemRdEn=1 and MemSel=1 for one cycle next cycle; go to WAIT1.
  - Otherwise: register the result, go to OUT.
- WAIT1: on MemValid, capture Hi=MemData, register the result, go to OUT.
- OUT:
  - NDValid=1; ND and NDTag are held stable until NDReady=1, then go to IDLE.
  - ReqReady=0 in OUT even in the handshake cycle, so there is no bypass; the next request is accepted one cycle later.
- Result computation:
  - F = ({Hi,Lo} >> (8*ALU))[8S-1:0]; Hi=0 when not Split.
  - Sign=1: ND = zero-extended F. Sign=0: ND = F sign-extended from bit 8S-1.
  - S=N gives F unchanged for aligned access.
- Latency: aligned request with memory latency 1 — accept at cycle T, MemRdEn at T+1, MemValid at T+2, NDValid at T+3. Split adds 2 cycles.
- MemValid outside WAIT0/WAIT1 is ignored.
- ReqValid outside IDLE is ignored; requests are not queued.
- Reset mid-operation aborts the load: no NDValid, and a subsequent stale MemValid is ignored.
- NDValid never deasserts without NDReady.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output port Trap (1 bit, reset 0).
  - A Split request issues no second read. In WAIT0 on MemValid it goes to OUT with ND=0, and Trap=1 alongside NDValid for the same cycles.
  - Aligned loads behave as in the base design.
- Undefined: no Trap port; Split loads are serviced by two reads as above.

Test Plan:
- Byte, ALU=1, Sign=1, MemData=32'h0000FFFF -> ND=32'h000000FF, NDValid at T+3 with 1-cycle memory, Tag echoed on NDTag.
- Byte, ALU=1, Sign=0, MemData=32'h0000FFFF -> ND=32'hFFFFFFFF; Half, ALU=2, Sign=0, MemData=32'h80010000 -> ND=32'hFFFF8001.
- Split half, ALU=3, Sign=1:
  - Checks: two MemRdEn pulses (MemSel 0 then 1).
  - Data: Lo=32'hAB000000, Hi=32'h000000CD -> ND=32'h0000CDAB.
  - With MISALIGN_TRAP_EN: one read, ND=0, Trap=1.
- Back-pressure: NDReady=0 for 3 cycles -> ND/NDTag/NDValid stable, ReqReady=0; NDReady=1 -> IDLE, ReqReady=1 next cycle.
- Reset asserted in WAIT1, MemValid=1 the following cycle -> state IDLE, NDValid stays 0, all outputs 0.
- Word, ALU=0, Size=3 (clamped), MemData=32'hDEADBEEF -> ND=32'hDEADBEEF; stray MemValid in IDLE produces no output.
